// File: rtl/icache_pkg.sv
// Shared fetch-side bus widths and instruction-cache geometry for icache.
package icache_pkg;

    localparam int unsigned INST_ADDR_W    = 32;
    localparam int unsigned INST_W         = 32;
    localparam int unsigned ICACHE_INDEX_W = 7;
    localparam int unsigned ICACHE_ADDR_W  = 18;
    localparam int unsigned ICACHE_TAG_W   = ICACHE_ADDR_W - ICACHE_INDEX_W - 2;
    localparam int unsigned ICACHE_NUM     = 1 << ICACHE_INDEX_W;

    localparam logic [INST_W-1:0] ZERO_WORD  = '0;
    localparam logic              TRUE_V     = 1'b1;
    localparam logic              FALSE_V    = 1'b0;
    localparam logic              RST_ENABLE = 1'b1;

    typedef logic [INST_ADDR_W-1:0]  inst_addr_t;
    typedef logic [INST_W-1:0]       inst_t;
    typedef logic [ICACHE_TAG_W-1:0] icache_tag_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache with combinational lookup.
// Define ICACHE_FWD_EN to bypass a same-cycle refill onto a matching lookup.
module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_W = ICACHE_INDEX_W,
    parameter int unsigned ADDR_W  = ICACHE_ADDR_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] read_addr_i,
    output logic        hit_o,
    output logic [31:0] inst_o,
    input  logic        we_i,
    input  logic [31:0] write_addr_i,
    input  logic [31:0] write_inst_i
);

    localparam int unsigned TAG_W = ADDR_W - INDEX_W - 2;
    localparam int unsigned NUM   = 1 << INDEX_W;

    logic [NUM-1:0]     valid;
    logic [TAG_W-1:0]   tag_mem  [NUM];
    logic [INST_W-1:0]  data_mem [NUM];

    logic [INDEX_W-1:0] rd_idx;
    logic [TAG_W-1:0]   rd_tag;
    logic [INDEX_W-1:0] wr_idx;
    logic [TAG_W-1:0]   wr_tag;

    assign rd_idx = read_addr_i[INDEX_W+1:2];
    assign rd_tag = read_addr_i[ADDR_W-1:INDEX_W+2];
    assign wr_idx = write_addr_i[INDEX_W+1:2];
    assign wr_tag = write_addr_i[ADDR_W-1:INDEX_W+2];

    // Address bits outside the significant window carry no information.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{read_addr_i[31:ADDR_W], read_addr_i[1:0],
                                write_addr_i[31:ADDR_W], write_addr_i[1:0]};

    // Valid bits: reset and flush both dominate a refill.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            valid <= '0;
        end else if (flush_i) begin
            valid <= '0;
        end else if (we_i) begin
            valid[wr_idx] <= TRUE_V;
        end
    end

    // Tag and data are only meaningful behind a valid bit, so no reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= write_inst_i;
        end
    end

    always_comb begin
        hit_o  = FALSE_V;
        inst_o = ZERO_WORD;
        if (valid[rd_idx] && (tag_mem[rd_idx] == rd_tag)) begin
            hit_o  = TRUE_V;
            inst_o = data_mem[rd_idx];
        end
`ifdef ICACHE_FWD_EN
        if (we_i && !flush_i && (rst != RST_ENABLE) &&
            (write_addr_i[ADDR_W-1:2] == read_addr_i[ADDR_W-1:2])) begin
            hit_o  = TRUE_V;
            inst_o = write_inst_i;
        end
`endif
    end

endmodule
